// File: rtl/sipo_deserializer.sv
// sipo_deserializer
// Serial-in / parallel-out stage. Bits qualified by d_valid are shifted into a
// WIDTH-bit register; each completed word is handed to a one-entry holding
// register presented with a valid/ready handshake. A word completed while the
// holding register is still occupied and not being accepted is dropped and
// recorded in the sticky overrun flag.
module sipo_deserializer #(
    parameter int WIDTH     = 8,    // bits per word, 2..32
    parameter bit MSB_FIRST = 1'b1  // 1: first bit lands in out_data[WIDTH-1]
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     d,
    input  logic                     d_valid,
    input  logic                     clr,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_overrun;

    logic [WIDTH-1:0]   w_shift_next;
    logic               w_complete;

    // Next shift-register contents with the current bit inserted, and the
    // word-completion strobe (the edge that samples the last bit of a word).
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        w_shift_next = r_shift;
        w_complete   = 1'b0;
        if (MSB_FIRST) begin
            w_shift_next = {r_shift[WIDTH-2:0], d};
        end else begin
            w_shift_next = {d, r_shift[WIDTH-1:1]};
        end
        w_complete = d_valid && (r_bit_cnt == LAST_CNT);
    end

    // Shift register and partial-word bit counter; both hold across gaps.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers are updated with non-blocking assignments so
        // every always_ff sees the pre-edge value of every other register.
        if (!resetn) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (clr) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (d_valid) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_complete ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

    // Output handshake state machine: holding register, valid and overrun.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_EMPTY;
            r_out_data <= '0;
            r_overrun  <= 1'b0;
        end else if (clr) begin
            // An unconsumed word is discarded; the stale data stays in place
            // but is meaningless while out_valid is low.
            r_state   <= ST_EMPTY;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_complete) begin
                        r_out_data <= w_shift_next;
                        r_state    <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        // Accept; a word completing on the same edge replaces
                        // it with no bubble on out_valid.
                        if (w_complete) begin
                            r_out_data <= w_shift_next;
                        end else begin
                            r_state <= ST_EMPTY;
                        end
                    end else if (w_complete) begin
                        // The presented word must not change: drop the new one.
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = (r_state == ST_FULL);
    assign bit_cnt   = r_bit_cnt;
    assign overrun   = r_overrun;

endmodule
